sha_256_padder: RTL
===================

Name: sha_256_padder

Overview:
Message padder and block framer sitting directly upstream of the SHA-256 accelerator. Accepts an arbitrary-length message as a big-endian 32-bit word stream and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length. Emits 512-bit blocks that map directly onto the accelerator's 512-bit input_data / input_valid. Handles messages spanning multiple blocks, including the case where padding spills into an extra block.

Parameters:
LEN_W, 64, width of internal message bit-length counter; zero-extended to 64 bits in the length field; legal range 16..64.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  32  message word; byte 0 in [31:24]
in_valid  input  1  in_data valid
in_ready  output  1  padder can accept a word
in_last  input  1  current word is the final word of the message
in_bytes  input  3  valid bytes in the last word, 0..4; ignored (treated as 4) when in_last=0
block_data  output  512  padded block; word 0 in [511:480]
block_valid  output  1  block_data valid
block_ready  input  1  consumer takes the block; integrator drives this from accelerator idle
block_last  output  1  block is the final block of the message

Behaviour:
- Reset: async assert on rst_n low. All outputs 0; block_data 0. State returns to S_FILL; word index and length counter are cleared.
- Word transfer: occurs when in_valid && in_ready. Block transfer: occurs when block_valid && block_ready.
- States: S_FILL, S_EMIT, S_EXTRA.
- S_FILL:
  - in_ready=1, block_valid=0.
  - Each accepted word is written to word slot idx (0..15). idx increments. The length counter adds 8 * bytes.
  - Non-last word at idx=15 → S_EMIT with block_last=0. idx wraps to 0.
  - Last word: p = 4*idx + in_bytes. Bytes beyond in_bytes are zeroed, 0x80 goes at byte p, and the remaining bytes are zeroed.
    - p<=55: words 14-15 hold the final length (including this word) → S_EMIT, block_last=1.
    - 56<=p<=63: no length in this block → S_EMIT, block_last=0, extra_pend=1, pad80_pend=0.
    - p=64 (idx=15, in_bytes=4): no 0x80 in this block → S_EMIT, block_last=0, extra_pend=1, pad80_pend=1.
- S_EMIT:
  - in_ready=0, block_valid=1. block_data and block_last stay stable until the block is taken.
  - On transfer:
    - extra_pend → S_EXTRA.
    - block_last=1 → clear length counter and idx → S_FILL.
    - Otherwise → S_FILL.
- S_EXTRA: build the extra block in one cycle: word 0 = pad80_pend ? 32'h80000000 : 0; words 1-13 = 0; words 14-15 = length. Go to S_EMIT with block_last=1 and extra_pend cleared.
- Latency: block_valid rises exactly 1 cycle after the accepted word that completes the block. The extra block's block_valid rises 2 cycles after the preceding block transfers.
- in_last with in_bytes=0 at idx=0 is an empty message: one block, 0x80000000, length 0.
- Length counter wraps modulo 2^LEN_W. No error is flagged.
- Words offered while in_ready=0 are not consumed. The upstream source holds them.
- Reset mid-message discards all partial state. The block in flight is dropped and block_valid deasserts asynchronously.

Optional Feature:
SHA_256_PADDER_STATS_EN:
- Defined: adds output msg_count (32 bits). It increments by 1 on each block transfer with block_last=1, wraps at 2^32, and resets to 0 on rst_n.
- Undefined: no port and no counter. All other behaviour is identical.

Test Plan:
- "abc": in_data=0x61626300, in_last=1, in_bytes=3 → one block. Word0=0x61626380, words1-14=0, word15=0x00000018, block_last=1, valid 1 cycle after accept.
- Empty message: in_last=1, in_bytes=0 → word0=0x80000000, all other words 0, block_last=1.
- 56-byte message (14 words, last in_bytes=4) → block 1: word14=0x80000000, word15=0, last=0. Block 2: words0-13=0, word15=0x000001C0, last=1.
- 64-byte message (16 words) → block 1 = data, last=0. Block 2: word0=0x80000000, word15=0x00000200, last=1.
- Backpressure: block_ready held 0 for 10 cycles → block_data stable, in_ready=0, no words lost. Then two back-to-back 55-byte messages give length 0x1B8 each and one block each.
- Reset pulse (rst_n low) after 7 words → outputs 0 immediately. Next "abc" yields the exact block from the first scenario.

Source files
------------

// File: rtl/sha_256_padder_if.sv
// Stream bundle between the message source, the SHA-256 padder and the accelerator.
// The slave modport is the padder's view; the master modport is the source/consumer view.
interface sha_256_padder_if;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic [511:0] block_data;
    logic         block_valid;
    logic         block_ready;
    logic         block_last;

    modport slave (
        input  in_data, in_valid, in_last, in_bytes, block_ready,
        output in_ready, block_data, block_valid, block_last
    );

    modport master (
        output in_data, in_valid, in_last, in_bytes, block_ready,
        input  in_ready, block_data, block_valid, block_last
    );
endinterface

// File: rtl/sha_256_padder.sv
// FIPS 180-4 message padder/framer producing 512-bit blocks for the SHA-256 core.
// Optional SHA_256_PADDER_STATS_EN adds msg_count_o (count of final blocks taken).
module sha_256_padder #(
    parameter int LEN_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    sha_256_padder_if.slave    pad_if
`ifdef SHA_256_PADDER_STATS_EN
    ,
    output logic [31:0]        msg_count_o
`endif
);

    // state   | meaning
    // S_FILL  | accepting message words into slots 0..15
    // S_EMIT  | block presented, waiting for block_ready
    // S_EXTRA | building the spill block (optional 0x80, zeros, length)
    typedef enum logic [1:0] {S_FILL, S_EMIT, S_EXTRA} state_t;

    state_t               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [15:0][31:0]    blk_q, blk_d;
    logic                 last_q, last_d;
    logic                 extra_q, extra_d;
    logic                 pad80_q, pad80_d;
    logic                 in_ready_q;
    logic                 block_valid_q;

    logic                 accept;
    logic [2:0]           nbytes;
    logic [LEN_W-1:0]     len_sum;
    logic [6:0]           p;
    logic [31:0]          keep_mask;
    logic [31:0]          marker;

    assign accept  = pad_if.in_valid && in_ready_q;
    assign nbytes  = !pad_if.in_last ? 3'd4 :
                     (pad_if.in_bytes > 3'd4) ? 3'd4 : pad_if.in_bytes;
    assign len_sum = len_q + (LEN_W'(nbytes) << 3);
    assign p       = {1'b0, idx_q, 2'b00} + 7'(nbytes);

    always_comb begin
        keep_mask = 32'hFFFF_FFFF;
        marker    = 32'h0000_0000;
        case (nbytes)
            3'd0:    begin keep_mask = 32'h0000_0000; marker = 32'h8000_0000; end
            3'd1:    begin keep_mask = 32'hFF00_0000; marker = 32'h0080_0000; end
            3'd2:    begin keep_mask = 32'hFFFF_0000; marker = 32'h0000_8000; end
            3'd3:    begin keep_mask = 32'hFFFF_FF00; marker = 32'h0000_0080; end
            default: begin keep_mask = 32'hFFFF_FFFF; marker = 32'h0000_0000; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        blk_d   = blk_q;
        last_d  = last_q;
        extra_d = extra_q;
        pad80_d = pad80_q;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    len_d = len_sum;
                    idx_d = idx_q + 4'd1;
                    if (!pad_if.in_last) begin
                        blk_d[4'(15 - idx_q)] = pad_if.in_data;
                        if (idx_q == 4'd15) begin
                            last_d  = 1'b0;
                            state_d = S_EMIT;
                        end
                    end else begin
                        // Slots past the final word may hold the previous block's data.
                        for (int j = 0; j < 16; j++) begin
                            if (j > int'(idx_q)) blk_d[4'(15 - j)] = 32'h0;
                        end
                        blk_d[4'(15 - idx_q)] = (pad_if.in_data & keep_mask) | marker;
                        if (nbytes == 3'd4 && idx_q != 4'd15)
                            blk_d[4'(14 - idx_q)] = 32'h8000_0000;
                        if (p <= 7'd55) begin
                            blk_d[1:0] = 64'(len_sum);
                            last_d     = 1'b1;
                            extra_d    = 1'b0;
                            pad80_d    = 1'b0;
                        end else begin
                            last_d     = 1'b0;
                            extra_d    = 1'b1;
                            pad80_d    = (p == 7'd64);
                        end
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (pad_if.block_ready) begin
                    last_d = 1'b0;
                    if (extra_q) begin
                        state_d = S_EXTRA;
                    end else if (last_q) begin
                        len_d   = '0;
                        idx_d   = 4'd0;
                        state_d = S_FILL;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_EXTRA: begin
                blk_d      = '0;
                blk_d[15]  = pad80_q ? 32'h8000_0000 : 32'h0;
                blk_d[1:0] = 64'(len_q);
                last_d     = 1'b1;
                extra_d    = 1'b0;
                pad80_d    = 1'b0;
                state_d    = S_EMIT;
            end
            default: state_d = S_FILL;
        endcase
    end

    // Handshake outputs are registered from the next state so they read 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FILL;
            idx_q         <= 4'd0;
            len_q         <= '0;
            blk_q         <= '0;
            last_q        <= 1'b0;
            extra_q       <= 1'b0;
            pad80_q       <= 1'b0;
            in_ready_q    <= 1'b0;
            block_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            blk_q         <= blk_d;
            last_q        <= last_d;
            extra_q       <= extra_d;
            pad80_q       <= pad80_d;
            in_ready_q    <= (state_d == S_FILL);
            block_valid_q <= (state_d == S_EMIT);
        end
    end

    assign pad_if.in_ready    = in_ready_q;
    assign pad_if.block_valid = block_valid_q;
    assign pad_if.block_data  = blk_q;
    assign pad_if.block_last  = last_q;

`ifdef SHA_256_PADDER_STATS_EN
    logic [31:0] msg_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            msg_count_q <= 32'd0;
        else if (block_valid_q && pad_if.block_ready && last_q)
            msg_count_q <= msg_count_q + 32'd1;
    end

    assign msg_count_o = msg_count_q;
`endif

endmodule
